// File: rtl/s_axi_regfile_pkg.sv
// Shared types and the byte-strobe merge helper for the AXI register file.
package s_axi_regfile_pkg;

    localparam int MAX_DATA_W = 1024;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_AW,
        HAVE_W,
        RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_t;

    // Callers zero-extend to the maximum width and truncate the result back.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/s_axi_regfile.sv
// Single-beat AXI slave register file with independent read/write paths and
// a flat live-register output bus for the counter core.
module s_axi_regfile
    import s_axi_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 4,
    parameter int NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [ID_W-1:0]            awid_i,
    input  logic [ADDR_W-1:0]          awaddr_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [DATA_W/8-1:0]        wstrb_i,
    input  logic                       wlast_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    output logic [ID_W-1:0]            bid_o,
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    input  logic [ID_W-1:0]            arid_i,
    input  logic [ADDR_W-1:0]          araddr_i,
    input  logic                       arvalid_i,
    output logic                       arready_o,
    output logic [ID_W-1:0]            rid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [1:0]                 rresp_o,
    output logic                       rlast_o,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(NUM_REGS * STRB_W);

    logic [DATA_W-1:0] regs [NUM_REGS];

    wr_state_t          wr_state;
    rd_state_t          rd_state;
    logic [ID_W-1:0]    aw_id_q;
    logic [IDX_W-1:0]   aw_idx_q;
    logic               aw_err_q;
    logic [DATA_W-1:0]  w_data_q;
    logic [STRB_W-1:0]  w_strb_q;

    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [IDX_W-1:0]   aw_idx_in, ar_idx_in;
    logic               aw_err_in, ar_err_in;
    logic [IDX_W-1:0]   eff_idx;
    logic               eff_err;
    logic [ID_W-1:0]    eff_id;
    logic [DATA_W-1:0]  eff_data;
    logic [STRB_W-1:0]  eff_strb;
    logic               commit;
    logic               unused_wlast;

    assign unused_wlast = wlast_i;

    assign aw_hs = awvalid_i && awready_o;
    assign w_hs  = wvalid_i && wready_o;
    assign b_hs  = bvalid_o && bready_i;
    assign ar_hs = arvalid_i && arready_o;
    assign r_hs  = rvalid_o && rready_i;

    assign aw_idx_in = awaddr_i[IDX_W+OFF_W-1:OFF_W];
    assign aw_err_in = (awaddr_i >= ADDR_END);
    assign ar_idx_in = araddr_i[IDX_W+OFF_W-1:OFF_W];
    assign ar_err_in = (araddr_i >= ADDR_END);

    // The half arriving on the committing edge bypasses its buffer.
    always_comb begin
        eff_idx  = aw_idx_in;
        eff_err  = aw_err_in;
        eff_id   = awid_i;
        eff_data = wdata_i;
        eff_strb = wstrb_i;
        if (wr_state == HAVE_AW) begin
            eff_idx = aw_idx_q;
            eff_err = aw_err_q;
            eff_id  = aw_id_q;
        end
        if (wr_state == HAVE_W) begin
            eff_data = w_data_q;
            eff_strb = w_strb_q;
        end
    end

    assign commit = ((wr_state == IDLE)    && aw_hs && w_hs) ||
                    ((wr_state == HAVE_AW) && w_hs) ||
                    ((wr_state == HAVE_W)  && aw_hs);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state  <= IDLE;
            awready_o <= 1'b1;
            wready_o  <= 1'b1;
            bvalid_o  <= 1'b0;
            bid_o     <= '0;
            bresp_o   <= OKAY;
            aw_id_q   <= '0;
            aw_idx_q  <= '0;
            aw_err_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            wr_state  <= RESP;
            awready_o <= 1'b0;
            wready_o  <= 1'b0;
            bvalid_o  <= 1'b1;
            bid_o     <= eff_id;
            bresp_o   <= eff_err ? SLVERR : OKAY;
        end else begin
            case (wr_state)
                IDLE: begin
                    if (aw_hs) begin
                        wr_state  <= HAVE_AW;
                        awready_o <= 1'b0;
                        aw_id_q   <= awid_i;
                        aw_idx_q  <= aw_idx_in;
                        aw_err_q  <= aw_err_in;
                    end else if (w_hs) begin
                        wr_state <= HAVE_W;
                        wready_o <= 1'b0;
                        w_data_q <= wdata_i;
                        w_strb_q <= wstrb_i;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        wr_state  <= IDLE;
                        awready_o <= 1'b1;
                        wready_o  <= 1'b1;
                        bvalid_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (commit && !eff_err) begin
            regs[eff_idx] <= DATA_W'(strb_merge(MAX_DATA_W'(regs[eff_idx]),
                                                MAX_DATA_W'(eff_data),
                                                MAX_STRB_W'(eff_strb)));
        end
    end

    // Sampling regs here on a commit edge yields the pre-write value.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rd_state  <= R_IDLE;
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
            rlast_o   <= 1'b0;
            rid_o     <= '0;
            rdata_o   <= '0;
            rresp_o   <= OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state  <= R_VALID;
                        arready_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        rlast_o   <= 1'b1;
                        rid_o     <= arid_i;
                        rdata_o   <= ar_err_in ? '0 : regs[ar_idx_in];
                        rresp_o   <= ar_err_in ? SLVERR : OKAY;
                    end
                end
                R_VALID: begin
                    if (r_hs) begin
                        rd_state  <= R_IDLE;
                        arready_o <= 1'b1;
                        rvalid_o  <= 1'b0;
                        rlast_o   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_o[k*DATA_W +: DATA_W] = regs[k];
    end

endmodule

// File: tb/tb_s_axi_regfile.sv
// Directed bench for s_axi_regfile: a transaction-level model checked every
// cycle, plus literal expectations at the interesting points.
module tb_s_axi_regfile;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [255:0] regs_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    s_axi_regfile #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .NUM_REGS(8)) dut (
        .clk(clk), .areset(areset),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
        .rready_i(rready), .regs_o(regs_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_of(input int k);
        return regs_o[k*32 +: 32];
    endfunction

    // Transaction-level model: buffers as flags, registers as a word array.
    logic        m_aw_full, m_w_full, m_b_pend, m_r_pend;
    logic [31:0] m_aw_addr, m_w_data, m_rdata;
    logic [3:0]  m_aw_id, m_w_strb, m_bid, m_rid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_regs [8];

    task automatic model_step();
        logic awhs, whs, arhs, bhs, rhs;
        if (!areset) begin
            m_aw_full = 0; m_w_full = 0; m_b_pend = 0; m_r_pend = 0;
            m_aw_addr = 0; m_w_data = 0; m_rdata = 0;
            m_aw_id = 0; m_w_strb = 0; m_bid = 0; m_rid = 0;
            m_bresp = 0; m_rresp = 0;
            for (int k = 0; k < 8; k++) m_regs[k] = 0;
        end else begin
            awhs = awvalid && !m_aw_full;
            whs  = wvalid && !m_w_full;
            arhs = arvalid && !m_r_pend;
            bhs  = bready && m_b_pend;
            rhs  = rready && m_r_pend;
            if (rhs) m_r_pend = 0;
            if (arhs) begin
                m_r_pend = 1;
                m_rid = arid;
                if (araddr < 32) begin
                    m_rdata = m_regs[araddr / 4];
                    m_rresp = 2'b00;
                end else begin
                    m_rdata = 0;
                    m_rresp = 2'b10;
                end
            end
            if (bhs) begin
                m_aw_full = 0; m_w_full = 0; m_b_pend = 0;
            end else begin
                if (awhs) begin m_aw_full = 1; m_aw_addr = awaddr; m_aw_id = awid; end
                if (whs)  begin m_w_full = 1; m_w_data = wdata; m_w_strb = wstrb; end
                if (m_aw_full && m_w_full && !m_b_pend) begin
                    if (m_aw_addr < 32) begin
                        for (int b = 0; b < 4; b++)
                            if (m_w_strb[b]) m_regs[m_aw_addr / 4][b*8 +: 8] = m_w_data[b*8 +: 8];
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                    m_bid = m_aw_id;
                    m_b_pend = 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge areset);
        model_step();
    end

    always @(negedge clk) begin
        chk("awready", 32'(awready), 32'(!m_aw_full));
        chk("wready",  32'(wready),  32'(!m_w_full));
        chk("bvalid",  32'(bvalid),  32'(m_b_pend));
        chk("bid",     32'(bid),     32'(m_bid));
        chk("bresp",   32'(bresp),   32'(m_bresp));
        chk("arready", 32'(arready), 32'(!m_r_pend));
        chk("rvalid",  32'(rvalid),  32'(m_r_pend));
        chk("rlast",   32'(rlast),   32'(m_r_pend));
        chk("rid",     32'(rid),     32'(m_rid));
        chk("rdata",   rdata,        m_rdata);
        chk("rresp",   32'(rresp),   32'(m_rresp));
        for (int k = 0; k < 8; k++) chk($sformatf("regs_o[%0d]", k), reg_of(k), m_regs[k]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input logic [31:0] a, input logic [3:0] id);
        awaddr = a; awid = id; awvalid = 1'b1;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        wdata = d; wstrb = s; wvalid = 1'b1;
    endtask

    task automatic drive_ar(input logic [31:0] a, input logic [3:0] id);
        araddr = a; arid = id; arvalid = 1'b1;
    endtask

    initial begin
        awid = 0; awaddr = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 1; wvalid = 0;
        arid = 0; araddr = 0; arvalid = 0;
        bready = 1; rready = 1;
        #1 areset = 1'b0;
        #1;
        chk("rst awready", 32'(awready), 1);
        chk("rst wready",  32'(wready), 1);
        chk("rst arready", 32'(arready), 1);
        chk("rst bvalid",  32'(bvalid), 0);
        chk("rst rvalid",  32'(rvalid), 0);
        chk("rst regs1",   reg_of(1), 0);
        repeat (2) @(posedge clk);
        #1 areset = 1'b1;

        // Same-cycle AW + W
        drive_aw(32'h04, 4'd3); drive_w(32'hDEADBEEF, 4'hF);
        step();
        awvalid = 0; wvalid = 0;
        chk("t1 bvalid", 32'(bvalid), 1);
        chk("t1 bid",    32'(bid), 3);
        chk("t1 bresp",  32'(bresp), 0);
        chk("t1 reg1",   reg_of(1), 32'hDEADBEEF);
        step();
        chk("t1 bvalid after hs", 32'(bvalid), 0);

        // W first, AW three cycles later, B stalled
        drive_w(32'h000000AA, 4'h1);
        step();
        wvalid = 0;
        chk("t2 wready", 32'(wready), 0);
        chk("t2 awready", 32'(awready), 1);
        bready = 0;
        step(); step();
        drive_aw(32'h04, 4'd2);
        step();
        awvalid = 0;
        chk("t2 reg1", reg_of(1), 32'hDEADBEAA);
        for (int i = 0; i < 3; i++) begin
            chk("t2 bvalid held", 32'(bvalid), 1);
            chk("t2 bid held", 32'(bid), 2);
            chk("t2 awready low", 32'(awready), 0);
            chk("t2 wready low", 32'(wready), 0);
            if (i < 2) step();
        end
        bready = 1;
        step();
        chk("t2 bvalid done", 32'(bvalid), 0);
        chk("t2 awready back", 32'(awready), 1);

        // Read with R stalled
        rready = 0;
        drive_ar(32'h04, 4'd5);
        step();
        arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t3 rdata", rdata, 32'hDEADBEAA);
            chk("t3 rid", 32'(rid), 5);
            chk("t3 rresp", 32'(rresp), 0);
            chk("t3 rlast", 32'(rlast), 1);
            chk("t3 arready low", 32'(arready), 0);
            if (i < 2) step();
        end
        rready = 1;
        step();
        chk("t3 rvalid done", 32'(rvalid), 0);
        chk("t3 arready back", 32'(arready), 1);

        // Out-of-range write and read
        drive_aw(32'h20, 4'd7); drive_w(32'h12345678, 4'hF);
        step();
        awvalid = 0; wvalid = 0;
        chk("t4 bresp", 32'(bresp), 2);
        chk("t4 reg0", reg_of(0), 0);
        chk("t4 reg1", reg_of(1), 32'hDEADBEAA);
        step();
        drive_ar(32'h20, 4'd1);
        step();
        arvalid = 0;
        chk("t4 rresp", 32'(rresp), 2);
        chk("t4 rdata", rdata, 0);
        step();

        // Write commit and read of the same register on one edge
        drive_aw(32'h08, 4'd6); drive_w(32'h0BADF00D, 4'hF); drive_ar(32'h08, 4'd9);
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t5 rdata old", rdata, 0);
        chk("t5 reg2 new", reg_of(2), 32'h0BADF00D);
        step();
        drive_ar(32'h08, 4'd9);
        step();
        arvalid = 0;
        chk("t5 rdata new", rdata, 32'h0BADF00D);
        step();

        // Partial strobes, then back-to-back zero-strobe write
        drive_aw(32'h0C, 4'd1); drive_w(32'h11223344, 4'h6);
        step();
        awvalid = 0; wvalid = 0;
        chk("t6 reg3", reg_of(3), 32'h00223300);
        step();
        drive_aw(32'h06, 4'd8); drive_w(32'hFFFFFFFF, 4'h0);
        step();
        awvalid = 0; wvalid = 0;
        chk("t6 bresp zero strb", 32'(bresp), 0);
        chk("t6 reg1 unchanged", reg_of(1), 32'hDEADBEAA);
        step();

        // Asynchronous reset while holding a buffered AW
        drive_aw(32'h10, 4'd4);
        step();
        awvalid = 0;
        chk("t7 awready", 32'(awready), 0);
        chk("t7 wready", 32'(wready), 1);
        #2 areset = 1'b0;
        #1;
        chk("t7 async awready", 32'(awready), 1);
        chk("t7 async bvalid", 32'(bvalid), 0);
        chk("t7 async rdata", rdata, 0);
        for (int k = 0; k < 8; k++) chk("t7 async regs", reg_of(k), 0);
        @(posedge clk);
        #1 areset = 1'b1;
        drive_w(32'h00000055, 4'hF);
        step();
        wvalid = 0;
        chk("t7 no commit bvalid", 32'(bvalid), 0);
        chk("t7 w buffered", 32'(wready), 0);
        step();
        chk("t7 reg4 untouched", reg_of(4), 0);
        drive_aw(32'h10, 4'd4);
        step();
        awvalid = 0;
        chk("t7 bvalid", 32'(bvalid), 1);
        chk("t7 bid", 32'(bid), 4);
        chk("t7 reg4", reg_of(4), 32'h00000055);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_axi_regfile.md
# s_axi_regfile

Parametrised AXI slave register file: the successor of the fixed 8×32 write-only register slave. It adds full-strobe writes, a read channel, ID echo, SLVERR on out-of-range addresses, and a flat register output bus for the counter logic. It sits between the AXI interconnect and the counter core. Transfers are single-beat only, with one outstanding write and one outstanding read.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 32, address width
- ID_W, 4, AXI ID width
- NUM_REGS, 8, register count; power of two, ≥2
- clk  in  1  single clock, rising edge
- areset  in  1  reset, asynchronous, active-low
- awid_i / awaddr_i / awvalid_i  in  ID_W / ADDR_W / 1  write address channel
- awready_o  out  1
- wdata_i / wstrb_i / wlast_i / wvalid_i  in  DATA_W / DATA_W/8 / 1 / 1  write data channel; wlast_i ignored
- wready_o  out  1
- bid_o / bresp_o / bvalid_o  out  ID_W / 2 / 1  write response channel
- bready_i  in  1
- arid_i / araddr_i / arvalid_i  in  ID_W / ADDR_W / 1  read address channel
- arready_o  out  1
- rid_o / rdata_o / rresp_o / rlast_o / rvalid_o  out  ID_W / DATA_W / 2 / 1 / 1  read data channel
- rready_i  in  1
- regs_o  out  NUM_REGS*DATA_W  live register contents; reg k at bits [k*DATA_W +: DATA_W]

## Operation
- **Address decode:** index = addr[log2(NUM_REGS)+B-1 : B], where B = log2(DATA_W/8). The low B bits are ignored.
  - Address ≥ NUM_REGS*DATA_W/8 is out of range and gets response SLVERR (2'b10). Otherwise the response is OKAY (2'b00).
- **Write buffering:** the AW and W channels are independent, each with a one-entry buffer. Either may handshake first, or both in the same cycle.
  - awready_o = AW buffer empty. wready_o = W buffer empty.
- **Write commit:** when both buffers are full and no B is pending, the write commits.
  - For each byte lane with its strobe set, the byte of the addressed register is updated. wstrb=0 leaves the register unchanged but still responds OKAY.
  - An out-of-range write modifies nothing.
  - On commit: bid_o = buffered awid, bresp_o is set, bvalid_o = 1.
  - Both buffers clear on the B handshake (bvalid_o && bready_i).
- **Read:** arready_o = 1 when no R beat is pending.
  - On AR handshake, the register is sampled into rdata_o. rid_o = arid_i, rresp_o is set, rlast_o = 1, rvalid_o = 1.
  - An out-of-range read returns rdata_o = 0 with SLVERR.
  - rvalid_o clears on rvalid_o && rready_i.
- **Output stability:** all B and R outputs are held stable while valid is high and ready is low.
- **Write FSM:** IDLE (neither buffered) → HAVE_AW / HAVE_W (one buffered) → RESP (committed, bvalid_o high) → IDLE on B handshake.
  - If AW and W handshake in the same cycle, IDLE goes directly to RESP.
- **Read FSM:** R_IDLE → R_VALID on AR handshake → R_IDLE on R handshake.

## Timing
- **Reset (areset low, asynchronous):**
  - awready_o = wready_o = arready_o = 1.
  - bvalid_o = rvalid_o = rlast_o = 0.
  - bid_o, bresp_o, rid_o, rdata_o, rresp_o = 0.
  - All registers = 0, so regs_o = 0.
  - Reset mid-transaction discards any buffered AW/W and any pending B/R; nothing commits.
- **Write latency:** last of the AW/W handshakes at edge N → register updated and bvalid_o high from edge N+1.
  - awready_o and wready_o stay low until the edge after the B handshake. Peak rate is one write every 2 cycles with bready_i held high.
- **Read latency:** AR handshake at edge N → rvalid_o and rdata_o from edge N+1.
  - arready_o is low while rvalid_o is high and returns high the edge after the R handshake.
- **Read/write collision:** a read sampled at the same edge as a write commit to the same register returns the old value. regs_o reflects the new value from edge N+1.
- **Independence:** the read and write paths never stall each other.

## Structure
- Package s_axi_regfile_pkg holds:
  - resp_t enum: OKAY = 2'b00, SLVERR = 2'b10.
  - wr_state_t enum: IDLE, HAVE_AW, HAVE_W, RESP.
  - rd_state_t enum: R_IDLE, R_VALID.
  - A strobe-merge function (old, new, strb) → merged word.
- No sub-module. The register array, both FSMs and the decode live in one module. The array is a single always_ff, the only driver of the registers.

## Test plan
- Reset, then AW 0x04 (id 3) and W 0xDEADBEEF (strb 0xF) in the same cycle → bvalid_o next cycle with bid_o=3, bresp_o=OKAY; regs_o reg1 = 0xDEADBEEF.
- W 0x000000AA (strb 0x1) at edge N, AW 0x04 (id 2) 3 cycles later, bready_i low for 2 cycles → reg1 = 0xDEADBEAA; bvalid_o held with bid_o=2 for all stalled cycles; awready_o/wready_o stay low until the edge after the B handshake.
- AR 0x04 (id 5), rready_i low for 3 cycles → rdata_o=0xDEADBEAA, rid_o=5, rresp_o=OKAY, rlast_o=1, all held stable; arready_o low until the edge after the R handshake.
- AW 0x20 (with NUM_REGS=8, DATA_W=32) → bresp_o=SLVERR and no register changes; AR 0x20 → rresp_o=SLVERR, rdata_o=0.
- Write to reg2 commits at the same edge as an AR to 0x08 → rdata_o = old value; a subsequent read returns the new value.
- Drop areset while in HAVE_AW with bvalid_o low → all outputs return to reset values asynchronously; a W arriving after reset release does not commit until a new AW arrives.
